// File: rtl/clk_period_monitor_pkg.sv
// Shared types and helpers for the clock period monitor.
// State encoding, default counter width and the distance helper.
package clk_period_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_t;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned CNT_MAX   = (32'd1 << CNT_W_DEF) - 32'd1;

  // One extra bit keeps the signed difference free of wrap.
  function automatic logic [32:0] abs_diff(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic signed [32:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? 33'(-d) : 33'(d);
  endfunction

endpackage

// File: rtl/clk_period_monitor_if.sv
// Control and result bundle of the clock period monitor.
// master drives enable and the monitored net; slave reports.
interface clk_period_monitor_if #(
  parameter int unsigned CNT_W = 16
);

  logic             en;
  logic             sig_in;
  logic             meas_valid;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             period_err;
  logic             stall_err;

  modport master (
    output en,
    output sig_in,
    input  meas_valid,
    input  period_out,
    input  high_out,
    input  period_err,
    input  stall_err
  );

  modport slave (
    input  en,
    input  sig_in,
    output meas_valid,
    output period_out,
    output high_out,
    output period_err,
    output stall_err
  );

endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer followed by a delay flop for edge detect.
// Every edge sees the same latency, so it cancels in measurements.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level = r_sync[SYNC_STAGES-1];
  assign rise  = level & ~r_prev;
  assign fall  = ~level & r_prev;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures high time and period of a foreign clock in local cycles,
// flags out-of-tolerance periods and stalled inputs.
module clk_period_monitor
  import clk_period_monitor_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned EXP_PERIOD  = 10,
  parameter int unsigned EXP_HIGH    = 5,
  parameter int unsigned TOL         = 1,
  parameter int unsigned TIMEOUT     = 1023,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  clk_period_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] L_CNT_MAX =
    (CNT_W == CNT_W_DEF) ? CNT_W'(CNT_MAX) : '1;
  localparam logic [CNT_W-1:0] L_TO_M1 = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high_q;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_meas_valid;
  logic             r_period_err;
  logic             r_stall_err;

  logic w_level;
  logic w_rise;
  logic w_fall;
  logic w_to;
  logic w_stall;
  logic w_report;
  logic w_hcap;
  logic w_cnt_clr;
  logic w_cnt_load;
  logic w_perr;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (bus.sig_in),
    .level (w_level),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  // Stall fires on the cycle the counter would reach TIMEOUT.
  assign w_to = (r_cnt == L_TO_M1);

  assign w_perr =
    (abs_diff(32'(r_cnt), 32'(EXP_PERIOD)) > 33'(TOL)) ||
    (abs_diff(32'(r_high_q), 32'(EXP_HIGH)) > 33'(TOL));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_stall    = 1'b0;
    w_report   = 1'b0;
    w_hcap     = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_load = 1'b0;
    if (!bus.en) begin
      w_state_nx = IDLE;
      w_cnt_clr  = 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nx = WAIT_RISE;
          w_cnt_clr  = 1'b1;
        end
        WAIT_RISE: begin
          if (w_rise) begin
            w_state_nx = HIGH;
            w_cnt_load = 1'b1;
          end else if (w_to) begin
            w_stall   = 1'b1;
            w_cnt_clr = 1'b1;
          end
        end
        HIGH: begin
          // A rise here means a missed fall: restart quietly.
          if (w_rise) begin
            w_cnt_load = 1'b1;
          end else if (w_to) begin
            w_stall    = 1'b1;
            w_cnt_clr  = 1'b1;
            w_state_nx = WAIT_RISE;
          end else if (w_fall && !w_level) begin
            w_hcap     = 1'b1;
            w_state_nx = LOW;
          end
        end
        LOW: begin
          if (w_rise) begin
            w_report   = 1'b1;
            w_cnt_load = 1'b1;
            w_state_nx = HIGH;
          end else if (w_to) begin
            w_stall    = 1'b1;
            w_cnt_clr  = 1'b1;
            w_state_nx = WAIT_RISE;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    r_cnt <= '0;
    else if (w_cnt_clr)         r_cnt <= '0;
    else if (w_cnt_load)        r_cnt <= CNT_W'(1);
    else if (r_cnt != L_CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_high_q     <= '0;
      r_period     <= '0;
      r_high       <= '0;
      r_meas_valid <= 1'b0;
      r_period_err <= 1'b0;
    end else begin
      r_meas_valid <= w_report;
      if (w_hcap) r_high_q <= r_cnt;
      if (w_report) begin
        r_period     <= r_cnt;
        r_high       <= r_high_q;
        r_period_err <= w_perr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                     r_stall_err <= 1'b0;
    else if (!bus.en || w_rise)  r_stall_err <= 1'b0;
    else if (w_stall)            r_stall_err <= 1'b1;
  end

  assign bus.meas_valid = r_meas_valid;
  assign bus.period_out = r_period;
  assign bus.high_out   = r_high;
  assign bus.period_err = r_period_err;
  assign bus.stall_err  = r_stall_err;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Scoreboard bench for clk_period_monitor: expected reports are
// queued as rises are driven and checked when meas_valid pulses.
module tb_clk_period_monitor;

  localparam int CNT_W   = 16;
  localparam int EXP_P   = 10;
  localparam int EXP_H   = 5;
  localparam int TOL     = 1;
  localparam int TIMEOUT = 1023;
  localparam int SYNC    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clk_period_monitor_if #(.CNT_W(CNT_W)) bus();

  clk_period_monitor #(
    .CNT_W      (CNT_W),
    .EXP_PERIOD (EXP_P),
    .EXP_HIGH   (EXP_H),
    .TOL        (TOL),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int h;
    bit e;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];
  int   mv_q[$];
  bit   have_prev = 1'b0;
  int   prev_hi   = 0;
  int   prev_lo   = 0;

  function automatic bit model_err(int p, int h);
    int dp;
    int dh;
    dp = p - EXP_P;
    dh = h - EXP_H;
    if (dp < 0) dp = -dp;
    if (dh < 0) dh = -dh;
    return (dp > TOL) || (dh > TOL);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.meas_valid === 1'b1) begin
      mv_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_report period=%0d high=%0d required none",
                 bus.period_out, bus.high_out);
      end else begin
        e = exp_q.pop_front();
        if (bus.period_out !== CNT_W'(e.p) ||
            bus.high_out !== CNT_W'(e.h) ||
            bus.period_err !== e.e) begin
          errors++;
          $display("FAIL report got p=%0d h=%0d err=%b required p=%0d h=%0d err=%b",
                   bus.period_out, bus.high_out, bus.period_err,
                   e.p, e.h, e.e);
        end
      end
    end
  end

  task automatic push_prev();
    exp_t e;
    if (have_prev) begin
      e.p = prev_hi + prev_lo;
      e.h = prev_hi;
      e.e = model_err(e.p, e.h);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_period(int hi, int lo);
    bus.sig_in = 1'b1;
    push_prev();
    repeat (hi) @(negedge clk);
    bus.sig_in = 1'b0;
    repeat (lo) @(negedge clk);
    prev_hi   = hi;
    prev_lo   = lo;
    have_prev = 1'b1;
  endtask

  task automatic final_rise();
    bus.sig_in = 1'b1;
    push_prev();
    have_prev = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic relock();
    bus.en     = 1'b0;
    bus.sig_in = 1'b0;
    repeat (6) @(negedge clk);
    have_prev = 1'b0;
    bus.en    = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_drained(string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.sig_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.meas_valid, bus.period_out, bus.high_out,
         bus.period_err, bus.stall_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs p=%0d h=%0d mv=%b required all 0",
               bus.period_out, bus.high_out, bus.meas_valid);
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.sig_in = ((i % 6) < 3);
      @(posedge clk);
      #1;
      checks++;
      if ({bus.meas_valid, bus.period_out, bus.high_out,
           bus.period_err, bus.stall_err} !== '0) begin
        errors++;
        $display("FAIL en_low_quiet cyc=%0d mv=%b p=%0d required all 0",
                 i, bus.meas_valid, bus.period_out);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_nominal();
    relock();
    mv_q.delete();
    repeat (4) drive_period(5, 5);
    final_rise();
    check_drained("nominal");
    checks++;
    if (mv_q.size() != 4) begin
      errors++;
      $display("FAIL nominal_count got %0d required 4", mv_q.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (mv_q[i] - mv_q[i-1] != 10) begin
          errors++;
          $display("FAIL nominal_spacing got %0d required 10",
                   mv_q[i] - mv_q[i-1]);
        end
      end
    end
    checks++;
    if (bus.stall_err !== 1'b0) begin
      errors++;
      $display("FAIL nominal_stall got %b required 0", bus.stall_err);
    end
  endtask

  task automatic test_mismatch();
    relock();
    repeat (2) drive_period(7, 7);
    checks++;
    if (bus.period_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got %b required 1", bus.period_err);
    end
    repeat (2) drive_period(5, 6);
    final_rise();
    check_drained("mismatch");
    checks++;
    if (bus.period_err !== 1'b0 || bus.period_out !== CNT_W'(11)) begin
      errors++;
      $display("FAIL err_clear err=%b p=%0d required 0 11",
               bus.period_err, bus.period_out);
    end
  endtask

  task automatic test_stall();
    int stall_at;
    relock();
    repeat (2) drive_period(5, 5);
    bus.sig_in = 1'b1;
    push_prev();
    have_prev = 1'b0;
    stall_at  = -1;
    for (int c = 1; c <= 1100; c++) begin
      @(posedge clk);
      #1;
      if (bus.stall_err === 1'b1 && stall_at < 0) stall_at = c;
      if (c == 5) begin
        @(negedge clk);
        bus.sig_in = 1'b0;
      end
    end
    // Rise is seen SYNC cycles after it is driven; stall follows TIMEOUT later.
    checks++;
    if (stall_at != TIMEOUT + SYNC) begin
      errors++;
      $display("FAIL stall_time got %0d required %0d",
               stall_at, TIMEOUT + SYNC);
    end
    checks++;
    if (bus.stall_err !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold got %b required 1", bus.stall_err);
    end
    @(negedge clk);
    bus.sig_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.stall_err !== 1'b1) begin
      errors++;
      $display("FAIL stall_pre_rise got %b required 1", bus.stall_err);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.stall_err !== 1'b0) begin
      errors++;
      $display("FAIL stall_clear got %b required 0", bus.stall_err);
    end
    @(negedge clk);
    repeat (2) @(negedge clk);
    bus.sig_in = 1'b0;
    repeat (5) @(negedge clk);
    prev_hi   = 5;
    prev_lo   = 5;
    have_prev = 1'b1;
    drive_period(5, 5);
    final_rise();
    check_drained("stall");
  endtask

  task automatic test_en_drop();
    relock();
    repeat (2) drive_period(5, 5);
    bus.sig_in = 1'b1;
    push_prev();
    repeat (5) @(negedge clk);
    bus.sig_in = 1'b0;
    repeat (3) @(negedge clk);
    bus.en    = 1'b0;
    have_prev = 1'b0;
    @(negedge clk);
    bus.en = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.period_out !== CNT_W'(10) || bus.high_out !== CNT_W'(5)) begin
      errors++;
      $display("FAIL en_drop_hold p=%0d h=%0d required 10 5",
               bus.period_out, bus.high_out);
    end
    repeat (2) drive_period(5, 5);
    final_rise();
    check_drained("en_drop");
  endtask

  task automatic test_reset_mid();
    relock();
    drive_period(5, 5);
    bus.sig_in = 1'b1;
    push_prev();
    have_prev = 1'b0;
    repeat (4) @(negedge clk);
    rst        = 1'b1;
    bus.sig_in = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.meas_valid, bus.period_out, bus.high_out,
         bus.period_err, bus.stall_err} !== '0) begin
      errors++;
      $display("FAIL rst_mid p=%0d h=%0d mv=%b required all 0",
               bus.period_out, bus.high_out, bus.meas_valid);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    repeat (3) drive_period(5, 5);
    final_rise();
    check_drained("rst_mid");
    checks++;
    if (bus.period_out !== CNT_W'(10) || bus.period_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_relock p=%0d err=%b required 10 0",
               bus.period_out, bus.period_err);
    end
  endtask

  initial begin
    bus.en     = 1'b0;
    bus.sig_in = 1'b0;
    test_reset();
    test_nominal();
    test_mismatch();
    test_stall();
    test_en_drop();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
